seg_scan_ctrl: RTL

Parametrised multiplexed seven-segment display scanner for the board I/O path.
- Drives N common-anode digits with a one-cold anode ring.
- Advances the ring on a programmable prescaler tick.
- Decodes a per-digit hex nibble to active-low segments, with decimal-point and blanking masks.
- Successor to the fixed 8-digit combinational ring step: adds a clock, counters, frame-coherent data capture and illegal-state recovery.

---
 rtl/seg_scan_pkg.sv | 14 +
 rtl/seg_scan_ctrl_hex7seg.sv | 11 +
 rtl/seg_scan_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the seven-segment scanner: segment type,
// the blank pattern and the active-low hex decode table {g,f,e,d,c,b,a}.
package seg_scan_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;

  localparam seg_t HEX7SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg_scan_ctrl_hex7seg.sv
// Combinational hex nibble to active-low seven-segment decode.
module hex7seg
  import seg_scan_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg
);

  assign seg = HEX7SEG_LUT[nibble];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed common-anode seven-segment scanner with prescaled one-cold ring,
// frame-coherent data snapshot and illegal-index recovery.
// Define SEG_SCAN_LZ_SUPPRESS_EN to blank leading-zero digits above the most
// significant nonzero nibble (digit 0 always shown).
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter  int NUM_DIGITS = 8,
  parameter  int PRESCALE   = 100000,
  localparam int IDX_W      = $clog2(NUM_DIGITS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic [IDX_W-1:0]        digit_idx,
  output logic                    frame_start
);

  localparam int               PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [PRE_W-1:0]        pre_cnt_q, pre_cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    primed_q, primed_d;
  logic [4*NUM_DIGITS-1:0] snap_data_q, snap_data_d;
  logic [NUM_DIGITS-1:0]   snap_dp_q, snap_dp_d;
  logic [NUM_DIGITS-1:0]   snap_blank_q, snap_blank_d;
  logic [NUM_DIGITS-1:0]   an_n_q, an_n_d;
  seg_t                    seg_n_q, seg_n_d;
  logic                    dp_n_q, dp_n_d;
  logic                    frame_start_q, frame_start_d;

  logic       tick, wrap, capture;
  logic [3:0] nib_sel;
  logic       dp_sel, blank_sel, blank_eff;
  seg_t       seg_dec;

  // >= rather than == so an upset count above the terminal value self-clears.
  always_comb begin
    tick          = en && (pre_cnt_q >= PRE_LAST);
    wrap          = tick && (idx_q == IDX_LAST);
    capture       = en && (!primed_q || wrap);
    pre_cnt_d     = pre_cnt_q;
    idx_d         = idx_q;
    primed_d      = primed_q | en;
    frame_start_d = wrap;
    snap_data_d   = snap_data_q;
    snap_dp_d     = snap_dp_q;
    snap_blank_d  = snap_blank_q;
    if (en) begin
      pre_cnt_d = tick ? '0 : pre_cnt_q + 1'b1;
      if (idx_q > IDX_LAST) begin
        idx_d = '0;
      end else if (tick) begin
        idx_d = wrap ? '0 : idx_q + 1'b1;
      end
    end
    if (capture) begin
      snap_data_d  = data;
      snap_dp_d    = dp_mask;
      snap_blank_d = blank_mask;
    end
  end

`ifdef SEG_SCAN_LZ_SUPPRESS_EN
  logic [NUM_DIGITS-1:0] lz_mask;
  logic                  lz_seen;

  always_comb begin
    lz_mask = '0;
    lz_seen = 1'b0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      if (snap_data_d[4*k +: 4] != 4'h0) lz_seen = 1'b1;
      lz_mask[k] = ~lz_seen;
    end
  end
`endif

  always_comb begin
    nib_sel   = 4'h0;
    dp_sel    = 1'b0;
    blank_sel = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_d == IDX_W'(k)) begin
        nib_sel   = snap_data_d[4*k +: 4];
        dp_sel    = snap_dp_d[k];
`ifdef SEG_SCAN_LZ_SUPPRESS_EN
        blank_sel = snap_blank_d[k] | lz_mask[k];
`else
        blank_sel = snap_blank_d[k];
`endif
      end
    end
  end

  hex7seg u_hex7seg (
    .nibble (nib_sel),
    .seg    (seg_dec)
  );

  // Blanked digits keep their anode active; only segments and dp go dark.
  always_comb begin
    blank_eff = blank_sel;
    an_n_d    = '1;
    seg_n_d   = SEG_BLANK;
    dp_n_d    = 1'b1;
    if (en) begin
      an_n_d  = ~(NUM_DIGITS'(1) << idx_d);
      seg_n_d = blank_eff ? SEG_BLANK : seg_dec;
      dp_n_d  = blank_eff | ~dp_sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_q     <= '0;
      idx_q         <= '0;
      primed_q      <= 1'b0;
      snap_data_q   <= '0;
      snap_dp_q     <= '0;
      snap_blank_q  <= '0;
      an_n_q        <= '1;
      seg_n_q       <= SEG_BLANK;
      dp_n_q        <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      pre_cnt_q     <= pre_cnt_d;
      idx_q         <= idx_d;
      primed_q      <= primed_d;
      snap_data_q   <= snap_data_d;
      snap_dp_q     <= snap_dp_d;
      snap_blank_q  <= snap_blank_d;
      an_n_q        <= an_n_d;
      seg_n_q       <= seg_n_d;
      dp_n_q        <= dp_n_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign an_n        = an_n_q;
  assign seg_n       = seg_n_q;
  assign dp_n        = dp_n_q;
  assign digit_idx   = idx_q;
  assign frame_start = frame_start_q;

endmodule
